// File: rtl/multicycle_controller.sv
// Multi-cycle sequencer for the RV32I-subset datapath (lw, sw, add/sub, addi, bne).
// Shares one memory port through a req/ready handshake and halts sticky on illegal opcodes.
module multicycle_controller #(
  parameter int CNT_W    = 32,
  parameter int MAX_WAIT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       op,
  input  logic [2:0]       func3,
  input  logic             func7b5,
  input  logic             eq,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             adr_src,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_write,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       imm_src,
  output logic [2:0]       alu_ctrl,
  output logic [1:0]       result_src,
  output logic             retire,
  output logic [CNT_W-1:0] retired_cnt,
  output logic             trap,
  output logic [3:0]       state_o
);

  localparam int WAIT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    TRAP     = 4'd10
  } state_t;

  state_t            state, state_n;
  logic [WAIT_W-1:0] wait_cnt;
  logic              req_state;
  logic              timeout;
  logic              handshake;

  assign req_state = (state == FETCH) || (state == MEMREAD) || (state == MEMWRITE);
  // A timed-out access may not complete even if ready arrives in the same cycle.
  assign timeout   = (MAX_WAIT != 0) && req_state && (wait_cnt == WAIT_W'(MAX_WAIT));
  assign handshake = req_state && mem_ready && !timeout;
  assign state_o   = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= FETCH;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      FETCH:    if (timeout) state_n = TRAP; else if (mem_ready) state_n = DECODE;
      DECODE: begin
        if (op == OP_LOAD || op == OP_STORE)             state_n = MEMADR;
        else if (op == OP_RTYPE)                         state_n = EXECR;
        else if (op == OP_ITYPE)                         state_n = EXECI;
        else if (op == OP_BRANCH && func3 == 3'b001)     state_n = BRANCH;
        else                                             state_n = TRAP;
      end
      MEMADR:   state_n = (op == OP_STORE) ? MEMWRITE : MEMREAD;
      MEMREAD:  if (timeout) state_n = TRAP; else if (mem_ready) state_n = MEMWB;
      MEMWB:    state_n = FETCH;
      MEMWRITE: if (timeout) state_n = TRAP; else if (mem_ready) state_n = FETCH;
      EXECR:    state_n = ALUWB;
      EXECI:    state_n = ALUWB;
      ALUWB:    state_n = FETCH;
      BRANCH:   state_n = FETCH;
      TRAP:     state_n = TRAP;
      default:  state_n = TRAP;
    endcase
  end

  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 2'd0;
    alu_src_b  = 2'd0;
    imm_src    = 2'd0;
    alu_ctrl   = 3'b000;
    result_src = 2'd0;
    retire     = 1'b0;
    trap       = 1'b0;
    // Everything is held low while reset is asserted, including FETCH's request.
    if (rst) begin
      case (state)
        FETCH: begin
          mem_req    = 1'b1;
          alu_src_b  = 2'd2;
          result_src = 2'd2;
          ir_write   = handshake;
          pc_write   = handshake;
        end
        DECODE: begin
          alu_src_a = 2'd1;
          alu_src_b = 2'd1;
          imm_src   = 2'd2;
        end
        MEMADR: begin
          alu_src_a = 2'd2;
          alu_src_b = 2'd1;
          imm_src   = (op == OP_STORE) ? 2'd1 : 2'd0;
        end
        MEMREAD: begin
          mem_req = 1'b1;
          adr_src = 1'b1;
        end
        MEMWB: begin
          result_src = 2'd1;
          reg_write  = 1'b1;
          retire     = 1'b1;
        end
        MEMWRITE: begin
          mem_req = 1'b1;
          mem_we  = !timeout;
          adr_src = 1'b1;
          retire  = handshake;
        end
        EXECR: begin
          alu_src_a = 2'd2;
          alu_ctrl  = (func7b5 && func3 == 3'b000) ? 3'b001 : 3'b000;
        end
        EXECI: begin
          alu_src_a = 2'd2;
          alu_src_b = 2'd1;
        end
        ALUWB: begin
          reg_write = 1'b1;
          retire    = 1'b1;
        end
        BRANCH: begin
          alu_src_a = 2'd2;
          alu_ctrl  = 3'b001;
          pc_write  = !eq;
          retire    = 1'b1;
        end
        TRAP:    trap = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retired_cnt <= '0;
      wait_cnt    <= '0;
    end else begin
      if (retire) retired_cnt <= retired_cnt + CNT_W'(1);
      if (state_n != state || (req_state && mem_ready)) wait_cnt <= '0;
      else if (req_state)                               wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: instruction-level expected traces checked every cycle,
// plus literal checks on retire timing, reset and trap behaviour.
module tb_multicycle_controller;

  localparam int CW = 32;
  localparam logic Y = 1'b1;
  localparam logic N = 1'b0;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] BAD = 7'b1111111;

  logic          clk = 1'b0;
  logic          rst;
  logic [6:0]    op;
  logic [2:0]    func3;
  logic          func7b5, eq, mem_ready;
  logic          mem_req, mem_we, adr_src, ir_write, pc_write, reg_write;
  logic [1:0]    alu_src_a, alu_src_b, imm_src, result_src;
  logic [2:0]    alu_ctrl;
  logic          retire, trap;
  logic [CW-1:0] retired_cnt;
  logic [3:0]    state_o;

  always #5 clk = ~clk;

  multicycle_controller #(.CNT_W(CW), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst), .op(op), .func3(func3), .func7b5(func7b5), .eq(eq),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .adr_src(adr_src),
    .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src),
    .alu_ctrl(alu_ctrl), .result_src(result_src), .retire(retire),
    .retired_cnt(retired_cnt), .trap(trap), .state_o(state_o)
  );

  typedef struct {
    logic [6:0]    op;
    logic [2:0]    f3;
    logic          f7;
    logic          eq;
    logic          rdy;
    logic [3:0]    st;
    logic [18:0]   ctl;
    logic [CW-1:0] cnt;
  } rec_t;

  rec_t          q[$];
  logic [6:0]    c_op;
  logic [2:0]    c_f3;
  logic          c_f7, c_eq;
  logic [CW-1:0] mcnt;
  int            total = 0;
  int            bad = 0;
  int            cyc = 0;
  int            ret_cyc[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // ctl = {req, we, adr, irw, pcw, rw, a, b, imm, alu, res, retire, trap}
  task automatic push(input logic [3:0] st, input logic rdy,
                      input logic req, input logic we, input logic adr,
                      input logic irw, input logic pcw, input logic rw,
                      input logic [1:0] a, input logic [1:0] b, input logic [1:0] imm,
                      input logic [2:0] alu, input logic [1:0] res, input logic ret);
    rec_t r;
    r.op = c_op; r.f3 = c_f3; r.f7 = c_f7; r.eq = c_eq; r.rdy = rdy; r.st = st;
    r.ctl = {req, we, adr, irw, pcw, rw, a, b, imm, alu, res, ret, (st == 4'd10)};
    r.cnt = mcnt;
    if (ret) mcnt = mcnt + 1;
    q.push_back(r);
  endtask

  task automatic fetch(input int waits);
    for (int i = 0; i < waits; i++)
      push(4'd0, N, Y, N, N, N, N, N, 2'd0, 2'd2, 2'd0, 3'd0, 2'd2, N);
    push(4'd0, Y, Y, N, N, Y, Y, N, 2'd0, 2'd2, 2'd0, 3'd0, 2'd2, N);
    push(4'd1, Y, N, N, N, N, N, N, 2'd1, 2'd1, 2'd2, 3'd0, 2'd0, N);
  endtask

  task automatic trap_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      c_eq = i[0];
      push(4'd10, i[1], N, N, N, N, N, N, 2'd0, 2'd0, 2'd0, 3'd0, 2'd0, N);
    end
  endtask

  // Expected cycle-by-cycle behaviour of one whole instruction.
  task automatic instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                       input logic e, input int fw, input int mw);
    c_op = o; c_f3 = f3; c_f7 = f7; c_eq = e;
    fetch(fw);
    if (o == LW) begin
      push(4'd2, N, N, N, N, N, N, N, 2'd2, 2'd1, 2'd0, 3'd0, 2'd0, N);
      for (int i = 0; i < mw; i++)
        push(4'd3, N, Y, N, Y, N, N, N, 2'd0, 2'd0, 2'd0, 3'd0, 2'd0, N);
      push(4'd3, Y, Y, N, Y, N, N, N, 2'd0, 2'd0, 2'd0, 3'd0, 2'd0, N);
      push(4'd4, N, N, N, N, N, N, Y, 2'd0, 2'd0, 2'd0, 3'd0, 2'd1, Y);
    end else if (o == SW) begin
      push(4'd2, N, N, N, N, N, N, N, 2'd2, 2'd1, 2'd1, 3'd0, 2'd0, N);
      for (int i = 0; i < mw; i++)
        push(4'd5, N, Y, Y, Y, N, N, N, 2'd0, 2'd0, 2'd0, 3'd0, 2'd0, N);
      push(4'd5, Y, Y, Y, Y, N, N, N, 2'd0, 2'd0, 2'd0, 3'd0, 2'd0, Y);
    end else if (o == RT) begin
      push(4'd6, N, N, N, N, N, N, N, 2'd2, 2'd0, 2'd0,
           (f7 && f3 == 3'b000) ? 3'd1 : 3'd0, 2'd0, N);
      push(4'd8, N, N, N, N, N, N, Y, 2'd0, 2'd0, 2'd0, 3'd0, 2'd0, Y);
    end else if (o == IT) begin
      push(4'd7, N, N, N, N, N, N, N, 2'd2, 2'd1, 2'd0, 3'd0, 2'd0, N);
      push(4'd8, N, N, N, N, N, N, Y, 2'd0, 2'd0, 2'd0, 3'd0, 2'd0, Y);
    end else if (o == BR && f3 == 3'b001) begin
      push(4'd9, N, N, N, N, N, !e, N, 2'd2, 2'd0, 2'd0, 3'd1, 2'd0, Y);
    end else begin
      trap_cycles(100);
    end
  endtask

  // Single compare process: drive each record after the edge, check at the falling edge.
  task automatic run();
    rec_t        r;
    logic [18:0] got;
    while (q.size() > 0) begin
      r = q.pop_front();
      op = r.op; func3 = r.f3; func7b5 = r.f7; eq = r.eq; mem_ready = r.rdy;
      @(negedge clk);
      cyc++;
      got = {mem_req, mem_we, adr_src, ir_write, pc_write, reg_write, alu_src_a,
             alu_src_b, imm_src, alu_ctrl, result_src, retire, trap};
      if (retire) ret_cyc.push_back(cyc);
      chk("state", 64'(state_o), 64'(r.st));
      chk("ctl", 64'(got), 64'(r.ctl));
      chk("retired_cnt", 64'(retired_cnt), 64'(r.cnt));
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    mcnt = '0;
  endtask

  initial begin
    int            exp_ret[5];
    logic [CW-1:0] cnt_before;
    exp_ret = '{4, 8, 13, 17, 20};
    rst = 1'b0; op = '0; func3 = '0; func7b5 = 1'b0; eq = 1'b0; mem_ready = 1'b1;
    mcnt = '0;
    #1;
    chk("reset_state", 64'(state_o), 64'd0);
    chk("reset_req", 64'({mem_req, ir_write, pc_write, reg_write, retire}), 64'd0);
    chk("reset_cnt", 64'(retired_cnt), 64'd0);
    do_reset();

    // Zero-wait stream: addi, add, lw, sw, taken bne.
    cyc = 0;
    instr(IT, 3'b000, N, N, 0, 0);
    instr(RT, 3'b000, N, N, 0, 0);
    instr(LW, 3'b010, N, N, 0, 0);
    instr(SW, 3'b010, N, N, 0, 0);
    instr(BR, 3'b001, N, N, 0, 0);
    run();
    chk("retire_count", 64'(ret_cyc.size()), 64'd5);
    for (int i = 0; i < 5; i++)
      chk("retire_cycle", 64'((i < ret_cyc.size()) ? ret_cyc[i] : -1), 64'(exp_ret[i]));
    chk("stream_cnt", 64'(retired_cnt), 64'd5);

    // Delayed fetch, sub vs add decoding, untaken branch, waited memory accesses.
    instr(RT, 3'b000, Y, N, 3, 0);
    instr(RT, 3'b001, Y, N, 0, 0);
    instr(RT, 3'b000, N, N, 0, 0);
    instr(BR, 3'b001, N, Y, 0, 0);
    instr(IT, 3'b000, N, N, 1, 0);
    instr(LW, 3'b010, N, N, 0, 2);
    instr(SW, 3'b010, N, N, 2, 3);
    run();
    chk("mid_cnt", 64'(retired_cnt), 64'd12);

    // Reset while a store is waiting in MEMWRITE.
    c_op = SW; c_f3 = 3'b010; c_f7 = N; c_eq = N;
    fetch(0);
    push(4'd2, N, N, N, N, N, N, N, 2'd2, 2'd1, 2'd1, 3'd0, 2'd0, N);
    push(4'd5, N, Y, Y, Y, N, N, N, 2'd0, 2'd0, 2'd0, 3'd0, 2'd0, N);
    push(4'd5, N, Y, Y, Y, N, N, N, 2'd0, 2'd0, 2'd0, 3'd0, 2'd0, N);
    run();
    mem_ready = 1'b0;
    rst = 1'b0;
    #1;
    chk("rst_mid_state", 64'(state_o), 64'd0);
    chk("rst_mid_we", 64'(mem_we), 64'd0);
    chk("rst_mid_req", 64'(mem_req), 64'd0);
    chk("rst_mid_cnt", 64'(retired_cnt), 64'd0);
    chk("rst_mid_trap", 64'(trap), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    mcnt = '0;
    instr(IT, 3'b000, N, N, 0, 0);
    run();

    // Load that never gets ready: four wait cycles, then the timeout cycle ignores a late ready.
    c_op = LW; c_f3 = 3'b010; c_f7 = N; c_eq = N;
    fetch(0);
    push(4'd2, N, N, N, N, N, N, N, 2'd2, 2'd1, 2'd0, 3'd0, 2'd0, N);
    for (int i = 0; i < 4; i++)
      push(4'd3, N, Y, N, Y, N, N, N, 2'd0, 2'd0, 2'd0, 3'd0, 2'd0, N);
    push(4'd3, Y, Y, N, Y, N, N, N, 2'd0, 2'd0, 2'd0, 3'd0, 2'd0, N);
    trap_cycles(20);
    cnt_before = mcnt;
    run();
    chk("timeout_state", 64'(state_o), 64'd10);
    chk("timeout_cnt", 64'(retired_cnt), 64'(cnt_before));
    chk("timeout_cnt_lit", 64'(retired_cnt), 64'd1);

    // Illegal opcode: sticky trap for 100 cycles.
    do_reset();
    instr(BAD, 3'b000, N, N, 0, 0);
    run();
    chk("illegal_trap", 64'(trap), 64'd1);
    chk("illegal_state", 64'(state_o), 64'd10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multi-cycle sequencer for the RV32I-subset datapath: lw, sw, R-type add/sub, addi, bne.
- Replaces the single-cycle decode path; instructions and data share one memory port with a req/ready handshake.
- Drives datapath muxes and enables state by state, counts retired instructions, and halts sticky on illegal opcodes.

Parameters:
- CNT_W, 32, width of retired-instruction counter
- MAX_WAIT, 255, memory-wait cycles before timeout trap (0 = no timeout)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- op  in  7  instruction[6:0], valid from DECODE on (IR output)
- func3  in  3  instruction[14:12]
- func7b5  in  1  instruction[30]
- eq  in  1  ALU zero flag, combinational from current ALU operands
- mem_ready  in  1  memory completes current request this cycle
- mem_req  out  1  memory request valid
- mem_we  out  1  memory write strobe, qualified by mem_req
- adr_src  out  1  0 = PC, 1 = ALUOut
- ir_write  out  1  latch IR and OldPC
- pc_write  out  1  PC load enable
- reg_write  out  1  register file write enable
- alu_src_a  out  2  0 = PC, 1 = OldPC, 2 = rs1
- alu_src_b  out  2  0 = rs2, 1 = imm, 2 = constant 4
- imm_src  out  2  0 = I, 1 = S, 2 = B
- alu_ctrl  out  3  000 add, 001 sub
- result_src  out  2  0 = ALUOut, 1 = mem data, 2 = ALU result
- retire  out  1  one-cycle pulse when an instruction completes
- retired_cnt  out  CNT_W  retired-instruction count, wraps modulo 2^CNT_W
- trap  out  1  sticky halt flag
- state_o  out  4  current state encoding, for debug

Behaviour:
- Reset (rst low, async): state = FETCH, retired_cnt = 0, trap = 0, wait counter = 0. All enables and strobes are 0 while rst is asserted. Muxes default to 0.
- Outputs are Moore-style from state, except handshake-qualified enables, which are combinational on mem_ready.
- Unlisted outputs in any state are 0.

State encoding and actions:
- FETCH (0):
  - mem_req = 1, adr_src = 0, alu_src_a = 0, alu_src_b = 2, alu_ctrl = add, result_src = 2.
  - While mem_ready = 0: stay.
  - When mem_ready = 1: ir_write = 1 and pc_write = 1 in the same cycle, then go to DECODE.
- DECODE (1):
  - alu_src_a = 1, alu_src_b = 1, imm_src = 2 (precomputes the branch target into ALUOut).
  - Next state by op:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXECR
    - 0010011 → EXECI
    - 1100011 with func3 = 001 → BRANCH
    - anything else → TRAP
- MEMADR (2):
  - alu_src_a = 2, alu_src_b = 1, add.
  - imm_src = 1 if op = store, else 0.
  - Next: MEMREAD for load, MEMWRITE for store.
- MEMREAD (3): mem_req = 1, adr_src = 1. Waits for mem_ready, then goes to MEMWB.
- MEMWB (4): result_src = 1, reg_write = 1, retire = 1. Next: FETCH.
- MEMWRITE (5): mem_req = 1, mem_we = 1, adr_src = 1. On mem_ready: retire = 1, next FETCH.
- EXECR (6):
  - alu_src_a = 2, alu_src_b = 0.
  - alu_ctrl = sub if func7b5 = 1 and func3 = 000, else add.
  - Next: ALUWB.
- EXECI (7): alu_src_a = 2, alu_src_b = 1, imm_src = 0, add. Next: ALUWB.
- ALUWB (8): result_src = 0, reg_write = 1, retire = 1. Next: FETCH.
- BRANCH (9):
  - alu_src_a = 2, alu_src_b = 0, sub, result_src = 0.
  - pc_write = !eq; retire = 1.
  - Next: FETCH.
- TRAP (10):
  - trap = 1; all enables 0.
  - Stays until reset. pc_write and reg_write never assert here.

Counters and wait timing:
- retired_cnt increments on every cycle where retire = 1. The count is visible the cycle after the pulse.
- Wait counter:
  - Increments each cycle that mem_req = 1 and mem_ready = 0.
  - Clears on mem_ready and on any state change.
  - If MAX_WAIT ≠ 0 and the counter reaches MAX_WAIT, the next state is TRAP (no enables in that cycle).
- mem_ready while mem_req = 0 is ignored.
- Reset asserted mid-access: state returns to FETCH immediately. No partial write is permitted after rst deasserts.
- Minimum latency with zero-wait memory:
  - lw 5 cycles
  - sw 4
  - R-type / addi 4
  - bne 3

Test Plan:
- Reset mid-MEMWRITE with mem_ready held 0, then release → state_o = 0, mem_we = 0, retired_cnt = 0, trap = 0.
- Zero-wait stream addi, add, lw, sw, bne(taken) → retire pulses at cycles 4, 8, 13, 17, 20; retired_cnt = 5; pc_write asserts in BRANCH only while eq = 0.
- FETCH with mem_ready delayed 3 cycles → mem_req high for 4 cycles; ir_write and pc_write each pulse exactly once, on the ready cycle.
- R-type with func7b5 = 1, func3 = 000 → alu_ctrl = 001 in EXECR; with func7b5 = 0 → 000.
- op = 1111111 → TRAP after DECODE; trap stays 1 for 100 cycles; no reg_write, pc_write or mem_req.
- MAX_WAIT = 4, mem_ready never asserted in MEMREAD → TRAP entered after 4 wait cycles; retired_cnt unchanged.
